// File: rtl/spi_flash_pkg.sv
// Shared constants for the SPI flash status-register responder: opcodes,
// status bit positions, synchronizer depth and the responder FSM encoding.
package spi_flash_pkg;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR1 = 8'h05;
  localparam logic [7:0] OP_RDSR2 = 8'h35;
  localparam logic [7:0] OP_WRSR  = 8'h01;

  localparam int SR_WIP = 0;
  localparam int SR_WEL = 1;

  // SR1 bits that WRSR data may touch; WIP/WEL are owned by the responder.
  localparam logic [7:0] SR1_DATA_MASK = 8'hFC;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XFER   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Byte presented on MISO for the given opcode; zero for anything but a read.
  function automatic logic [7:0] rdsr_byte(input logic [7:0] op,
                                           input logic [7:0] sr1,
                                           input logic [7:0] sr2);
    logic [7:0] b;
    b = 8'h00;
    if (op == OP_RDSR1) b = sr1;
    else if (op == OP_RDSR2) b = sr2;
    return b;
  endfunction

endpackage

// File: rtl/spi_flash_sr_resp_if.sv
// The four SPI pins plus the MISO output-enable, seen from the initiator
// (master) and from the flash responder (slave).
interface spi_flash_sr_resp_if;
  logic spi_clk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_clk, spi_cs_n, spi_mosi,
    input  spi_miso, spi_miso_oe
  );

  modport slave (
    input  spi_clk, spi_cs_n, spi_mosi,
    output spi_miso, spi_miso_oe
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Brings one asynchronous pin into the clk domain and registers its level
// and edges, so every pin lands with the same three-edge latency.
module spi_sync_edge
  import spi_flash_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic val,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Reset to the pin's idle level so releasing reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      val    <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      val    <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~val;
      fall   <= ~sync_q[SYNC_STAGES-1] & val;
    end
  end

endmodule

// File: rtl/spi_flash_sr_resp.sv
// SPI mode-0 responder for the status-register subset of a boot flash:
// WREN/WRDI/RDSR1/RDSR2/WRSR with a WIP busy window after each write.
module spi_flash_sr_resp
  import spi_flash_pkg::*;
#(
  parameter logic [15:0] SR_INIT     = 16'h0000,
  parameter logic [7:0]  SR2_WMASK   = 8'hFF,
  parameter int unsigned BUSY_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_flash_sr_resp_if.slave    spi,
  output logic [15:0]           sr,
  output logic                  sr_wr
);

  localparam int BCW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [BCW-1:0] BUSY_LOAD = BCW'(BUSY_CYCLES - 1);

  logic sck_val, sck_rise, sck_fall;
  logic cs_val, cs_rise, cs_fall;
  logic mosi_val, mosi_rise, mosi_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .din(spi.spi_clk),
    .val(sck_val), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .din(spi.spi_cs_n),
    .val(cs_val), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .din(spi.spi_mosi),
    .val(mosi_val), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Only SCK edges, CS level/rise and MOSI level drive the protocol.
  logic unused_edges;
  assign unused_edges = ^{sck_val, cs_fall, mosi_rise, mosi_fall};

  state_t          state;
  logic [2:0]      bit_cnt;
  logic [1:0]      byte_cnt;
  logic [7:0]      rx_sr;
  logic [7:0]      tx_sr;
  logic [7:0]      opcode;
  logic [7:0]      data1;
  logic [7:0]      data2;
  logic            miso_bit;
  logic [7:0]      sr1;
  logic [7:0]      sr2;
  logic [BCW-1:0]  busy_cnt;

  logic [7:0] rx_byte;
  logic [7:0] cur_op;

  assign rx_byte = {rx_sr[6:0], mosi_val};
  // While byte 0 completes the opcode register is not loaded yet.
  assign cur_op  = (byte_cnt == 2'd0) ? rx_byte : opcode;
  assign sr      = {sr2, sr1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      bit_cnt         <= 3'd0;
      byte_cnt        <= 2'd0;
      rx_sr           <= 8'h00;
      tx_sr           <= 8'h00;
      opcode          <= 8'h00;
      data1           <= 8'h00;
      data2           <= 8'h00;
      miso_bit        <= 1'b0;
      sr1             <= SR_INIT[7:0] & SR1_DATA_MASK;
      sr2             <= SR_INIT[15:8];
      busy_cnt        <= '0;
      sr_wr           <= 1'b0;
      spi.spi_miso    <= 1'b0;
      spi.spi_miso_oe <= 1'b0;
    end else begin
      sr_wr           <= 1'b0;
      spi.spi_miso_oe <= (state == ST_XFER);
      spi.spi_miso    <= (state == ST_XFER) & miso_bit;

      // Busy window; the commit below only fires with WIP clear, so the two never collide.
      if (sr1[SR_WIP]) begin
        if (busy_cnt == '0) begin
          sr1[SR_WIP] <= 1'b0;
          sr1[SR_WEL] <= 1'b0;
        end else begin
          busy_cnt <= busy_cnt - BCW'(1);
        end
      end

      case (state)
        ST_IDLE: begin
          bit_cnt  <= 3'd0;
          byte_cnt <= 2'd0;
          miso_bit <= 1'b0;
          tx_sr    <= 8'h00;
          if (!cs_val) state <= ST_XFER;
        end

        ST_XFER: begin
          if (cs_rise) begin
            state <= ST_COMMIT;
          end else if (sck_rise) begin
            rx_sr   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              case (byte_cnt)
                2'd0:    opcode <= rx_byte;
                2'd1:    data1  <= rx_byte;
                2'd2:    data2  <= rx_byte;
                default: ;
              endcase
              if (byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
              // Reload every byte so continuous reads track the live WIP bit.
              tx_sr <= rdsr_byte(cur_op, sr1, sr2);
            end
          end else if (sck_fall) begin
            miso_bit <= tx_sr[7];
            tx_sr    <= {tx_sr[6:0], 1'b0};
          end
        end

        ST_COMMIT: begin
          state <= ST_IDLE;
          if (bit_cnt == 3'd0 && byte_cnt != 2'd0 && !sr1[SR_WIP]) begin
            case (opcode)
              OP_WREN: sr1[SR_WEL] <= 1'b1;
              OP_WRDI: sr1[SR_WEL] <= 1'b0;
              OP_WRSR: begin
                if (sr1[SR_WEL] && byte_cnt >= 2'd2) begin
                  sr1[7:2]    <= data1[7:2];
                  sr1[SR_WIP] <= 1'b1;
                  if (byte_cnt == 2'd3)
                    sr2 <= (sr2 & ~SR2_WMASK) | (data2 & SR2_WMASK);
                  busy_cnt <= BUSY_LOAD;
                  sr_wr    <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_sr_resp.sv
// Bench for spi_flash_sr_resp: directed vector table, busy/reset sequences,
// then random command traffic against a transaction-level status model.
module tb_spi_flash_sr_resp;

  localparam int          BUSY    = 800;
  localparam logic [15:0] SR_INIT = 16'h00A0;
  localparam logic [7:0]  WMASK   = 8'h02;
  localparam int          HALF    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sr;
  logic        sr_wr;

  spi_flash_sr_resp_if spi();

  spi_flash_sr_resp #(
    .SR_INIT(SR_INIT), .SR2_WMASK(WMASK), .BUSY_CYCLES(BUSY)
  ) dut (
    .clk(clk), .rst(rst), .spi(spi), .sr(sr), .sr_wr(sr_wr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int wr_cnt  = 0;
  int wip_cyc = 0;

  always @(negedge clk) begin
    if (sr_wr)  wr_cnt  <= wr_cnt + 1;
    if (sr[0])  wip_cyc <= wip_cyc + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Mode-0 transfer of the top nbits of tx; rx holds MISO sampled before each rise.
  task automatic spi_xfer(input logic [31:0] tx, input int nbits,
                          output logic [31:0] rx, output logic oe);
    rx = 32'h0;
    oe = 1'b0;
    @(negedge clk);
    spi.spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi.spi_mosi = tx[31-i];
      repeat (HALF) @(negedge clk);
      rx[31-i] = spi.spi_miso;
      if (i == 0) oe = spi.spi_miso_oe;
      spi.spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi.spi_clk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi.spi_cs_n = 1'b1;
    spi.spi_mosi = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // Reference model: status register state at transaction granularity.
  logic [7:0] m_sr1, m_sr2;
  bit         m_wel, m_wip;

  function automatic logic [7:0] m_rd1();
    return {m_sr1[7:2], m_wel, m_wip};
  endfunction

  task automatic m_reset();
    m_sr1 = SR_INIT[7:0] & 8'hFC;
    m_sr2 = SR_INIT[15:8];
    m_wel = 1'b0;
    m_wip = 1'b0;
  endtask

  task automatic run_model_txn(input logic [31:0] tx, input int nbits, output bit committed);
    logic [31:0] rx, exp, mask;
    logic        oe;
    logic [7:0]  op, v;
    int          wr0;
    op   = tx[31:24];
    v    = (op == 8'h05) ? m_rd1() : (op == 8'h35) ? m_sr2 : 8'h00;
    exp  = {8'h00, v, v, v};
    mask = ~(32'hFFFF_FFFF >> nbits);
    wr0  = wr_cnt;
    spi_xfer(tx, nbits, rx, oe);
    committed = 1'b0;
    if (nbits % 8 == 0 && !m_wip) begin
      case (op)
        8'h06: m_wel = 1'b1;
        8'h04: m_wel = 1'b0;
        8'h01: if (m_wel && nbits >= 16) begin
          m_sr1 = {tx[23:18], 2'b00};
          if (nbits >= 24) m_sr2 = (m_sr2 & ~WMASK) | (tx[15:8] & WMASK);
          m_wip = 1'b1;
          committed = 1'b1;
        end
        default: ;
      endcase
    end
    chk($sformatf("rnd_rx op=%h n=%0d", op, nbits), rx & mask, exp & mask);
    chk("rnd_oe", 32'(oe), 32'd1);
    chk($sformatf("rnd_sr op=%h n=%0d", op, nbits), 32'(sr), 32'({m_sr2, m_rd1()}));
    chk("rnd_sr_wr", wr_cnt - wr0, 32'(committed));
  endtask

  typedef struct {
    logic [31:0] tx;
    int          nbits;
    logic [31:0] exp_rx;
    logic [15:0] exp_sr;
    int          exp_wr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] rx, mask;
    logic        oe;
    int          wr0, wip0, nbits, nb2;
    bit          c;
    logic [7:0]  op, op2;
    logic [31:0] d;

    vecs[0]  = '{32'h0500_0000, 16, 32'h00A0_0000, 16'h00A0, 0};
    vecs[1]  = '{32'h0600_0000,  8, 32'h0,         16'h00A2, 0};
    vecs[2]  = '{32'h0500_0000, 16, 32'h00A2_0000, 16'h00A2, 0};
    vecs[3]  = '{32'h0400_0000,  8, 32'h0,         16'h00A0, 0};
    vecs[4]  = '{32'h0500_0000, 24, 32'h00A0_A000, 16'h00A0, 0};
    vecs[5]  = '{32'h3500_0000, 24, 32'h0,         16'h00A0, 0};
    vecs[6]  = '{32'h011C_0000, 16, 32'h0,         16'h00A0, 0};
    vecs[7]  = '{32'h0600_0000,  8, 32'h0,         16'h00A2, 0};
    vecs[8]  = '{32'h0110_0000, 12, 32'h0,         16'h00A2, 0};
    vecs[9]  = '{32'h0500_0000, 16, 32'h00A2_0000, 16'h00A2, 0};
    vecs[10] = '{32'h9F00_0000, 16, 32'h0,         16'h00A2, 0};
    vecs[11] = '{32'h0400_0000,  9, 32'h0,         16'h00A2, 0};
    vecs[12] = '{32'h0400_0000,  8, 32'h0,         16'h00A0, 0};

    spi.spi_clk  = 1'b0;
    spi.spi_cs_n = 1'b1;
    spi.spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_sr_in_rst", 32'(sr), 32'h00A0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_sr", 32'(sr), 32'h00A0);
    chk("reset_miso", 32'(spi.spi_miso), 32'd0);
    chk("reset_oe", 32'(spi.spi_miso_oe), 32'd0);
    chk("reset_sr_wr", 32'(sr_wr), 32'd0);

    for (int i = 0; i < 13; i++) begin
      wr0 = wr_cnt;
      spi_xfer(vecs[i].tx, vecs[i].nbits, rx, oe);
      mask = ~(32'hFFFF_FFFF >> vecs[i].nbits);
      chk($sformatf("vec%0d_rx", i), rx & mask, vecs[i].exp_rx & mask);
      chk($sformatf("vec%0d_sr", i), 32'(sr), 32'(vecs[i].exp_sr));
      chk($sformatf("vec%0d_sr_wr", i), wr_cnt - wr0, vecs[i].exp_wr);
      chk($sformatf("vec%0d_oe_sel", i), 32'(oe), 32'd1);
      chk($sformatf("vec%0d_oe_idle", i), 32'(spi.spi_miso_oe), 32'd0);
    end

    // Accepted WRSR, read and discarded WRDI inside the busy window, then expiry.
    wr0 = wr_cnt;
    spi_xfer(32'h0600_0000, 8, rx, oe);
    chk("busy_wren_sr", 32'(sr), 32'h00A2);
    wip0 = wip_cyc;
    spi_xfer(32'h011C_0200, 24, rx, oe);
    chk("wrsr_sr", 32'(sr), 32'h021F);
    chk("wrsr_sr_wr", wr_cnt - wr0, 32'd1);
    spi_xfer(32'h0500_0000, 24, rx, oe);
    chk("busy_rdsr1", rx & 32'hFFFF_FF00, 32'h001F_1F00);
    spi_xfer(32'h0400_0000, 8, rx, oe);
    chk("busy_wrdi_ignored", 32'(sr), 32'h021F);
    repeat (BUSY + 20) @(negedge clk);
    chk("after_busy_sr", 32'(sr), 32'h021C);
    chk("wip_len", wip_cyc - wip0, BUSY);
    chk("busy_sr_wr_once", wr_cnt - wr0, 32'd1);

    // Reset asserted part-way through the RDSR1 response byte.
    @(negedge clk);
    spi.spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      spi.spi_mosi = (i == 5 || i == 7) ? 1'b1 : 1'b0;
      repeat (HALF) @(negedge clk);
      spi.spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi.spi_clk = 1'b0;
    end
    spi.spi_mosi = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("pre_rst_miso", 32'(spi.spi_miso), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_miso", 32'(spi.spi_miso), 32'd0);
    chk("rst_oe", 32'(spi.spi_miso_oe), 32'd0);
    chk("rst_sr", 32'(sr), 32'h00A0);
    spi.spi_cs_n = 1'b1;
    spi.spi_clk  = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    m_reset();
    run_model_txn(32'h0500_0000, 16, c);

    for (int it = 0; it < 30; it++) begin
      d = $urandom;
      nbits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 31))
                                           : 8 * int'($urandom_range(1, 4));
      case ($urandom_range(0, 6))
        0:       op = 8'h06;
        1:       op = 8'h04;
        2:       op = 8'h05;
        3:       op = 8'h35;
        4, 5:    op = 8'h01;
        default: op = 8'($urandom_range(0, 255));
      endcase
      if (op == 8'h01 && $urandom_range(0, 3) != 0) run_model_txn(32'h0600_0000, 8, c);
      run_model_txn({op, d[23:0]}, nbits, c);
      if (c) begin
        if ($urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 4))
            0:       op2 = 8'h05;
            1:       op2 = 8'h35;
            2:       op2 = 8'h06;
            3:       op2 = 8'h04;
            default: op2 = 8'h01;
          endcase
          nb2 = 8 * int'($urandom_range(1, 3));
          d = $urandom;
          run_model_txn({op2, d[23:0]}, nb2, c);
        end
        repeat (BUSY + 20) @(negedge clk);
        m_wip = 1'b0;
        m_wel = 1'b0;
        chk("rnd_busy_end_sr", 32'(sr), 32'({m_sr2, m_rd1()}));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
